// File: rtl/audio_pkg.sv
// Shared types and helpers for the sample-playback engine: FSM states, sample-rate
// divider derivation and the signed-sample to offset-binary PWM level mapping.
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    function automatic int divider_of(input int clock_rate, input int sample_rate);
        return clock_rate / sample_rate;
    endfunction

    // Attenuate, bias into offset binary, keep the top pwm_bits.
    // Adding half-scale is equivalent to inverting the MSB of the scaled sample.
    function automatic logic [31:0] to_offset_level(input logic signed [31:0] sample,
                                                    input logic [1:0]         shift,
                                                    input int                 sample_w,
                                                    input int                 pwm_bits);
        logic signed [31:0] scaled;
        logic [31:0]        offset;
        scaled = sample >>> shift;
        offset = 32'(scaled) + (32'd1 << (sample_w - 1));
        return offset >> (sample_w - pwm_bits);
    endfunction

endpackage

// File: rtl/audio_stream_player_pwm_dac.sv
// PWM DAC: free-running counter with a double-buffered threshold and registered output.
// New thresholds take effect only at period end, so a period never changes mid-way.
module pwm_dac #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                run,
    input  logic                pend_vld,
    input  logic [PWM_BITS-1:0] pend_level,
    output logic [PWM_BITS-1:0] level,
    output logic                audio_out
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pending   <= '0;
            level     <= '0;
            audio_out <= 1'b0;
        end else begin
            // Memory keeps answering while frozen, so captures are never gated.
            if (pend_vld)
                pending <= pend_level;
            if (!enable) begin
                audio_out <= 1'b0;
            end else if (run) begin
                cnt       <= cnt + 1'b1;
                audio_out <= (cnt < level);
                if (&cnt)
                    level <= pending;
            end else begin
                cnt       <= '0;
                audio_out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_stream_player.sv
// Streams signed PCM from a synchronous sample memory over a programmable window at a
// fixed sample rate, into a PWM DAC; sample capture lands MEM_LATENCY+1 cycles after a read issue.
module audio_stream_player
    import audio_pkg::*;
#(
    parameter int CLOCK_RATE  = 3_125_000,
    parameter int SAMPLE_RATE = 16_000,
    parameter int ADDR_W      = 14,
    parameter int SAMPLE_W    = 16,
    parameter int PWM_BITS    = 4,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_mode,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic [1:0]          vol_shift,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [SAMPLE_W-1:0] mem_data,
    output logic [ADDR_W-1:0]   current_addr,
    output logic                busy,
    output logic                done,
    output logic                audio_out,
    output logic [PWM_BITS-1:0] level
);

    localparam int DIVIDER = divider_of(CLOCK_RATE, SAMPLE_RATE);
    localparam int DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   start_lat, end_lat;
    logic                loop_lat;
    logic [DIV_W-1:0]    div_cnt;
    logic [MEM_LATENCY-1:0] rd_pipe;
    logic                tick, at_end, do_start, do_finish, issue_rd;
    logic signed [31:0]  sample_sx;
    logic [PWM_BITS-1:0] pend_level;

    assign tick   = (div_cnt == DIV_W'(DIVIDER - 1));
    assign at_end = (current_addr == end_lat);

    always_comb begin
        state_nx  = state;
        do_start  = 1'b0;
        do_finish = 1'b0;
        issue_rd  = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: if (start && !stop) begin
                    state_nx = PLAY;
                    do_start = 1'b1;
                    issue_rd = 1'b1;
                end
                PLAY: if (stop) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    if (at_end && !loop_lat) begin
                        state_nx  = IDLE;
                        do_finish = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            current_addr <= '0;
            start_lat    <= '0;
            end_lat      <= '0;
            loop_lat     <= 1'b0;
            div_cnt      <= '0;
            mem_rd_en    <= 1'b0;
            done         <= 1'b0;
            rd_pipe      <= '0;
        end else begin
            state     <= state_nx;
            // Strobes self-clear even while frozen so a read is never repeated.
            mem_rd_en <= issue_rd;
            done      <= do_finish;
            rd_pipe[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (do_start) begin
                start_lat    <= start_addr;
                end_lat      <= end_addr;
                loop_lat     <= loop_mode;
                current_addr <= start_addr;
                div_cnt      <= '0;
            end else if (enable && state == PLAY && !stop) begin
                if (tick) begin
                    div_cnt <= '0;
                    if (!at_end)
                        current_addr <= current_addr + 1'b1;
                    else if (loop_lat)
                        current_addr <= start_lat;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

    assign sample_sx  = {{(32 - SAMPLE_W){mem_data[SAMPLE_W-1]}}, mem_data};
    assign pend_level = PWM_BITS'(to_offset_level(sample_sx, vol_shift, SAMPLE_W, PWM_BITS));
    assign mem_addr   = current_addr;
    assign busy       = (state == PLAY);

    pwm_dac #(.PWM_BITS(PWM_BITS)) u_pwm_dac (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .run        (state == PLAY),
        .pend_vld   (rd_pipe[MEM_LATENCY-1]),
        .pend_level (pend_level),
        .level      (level),
        .audio_out  (audio_out)
    );

endmodule

// File: doc/audio_stream_player.md
Name: audio_stream_player

Overview:
Parametrised sample-playback engine. Streams signed PCM samples from an external synchronous sample memory over a programmable address window, at a fixed sample rate derived from clk. Supports one-shot or looped playback, start/stop control, and shift-based volume attenuation. Drives a glitch-free PWM 1-bit audio output. Sits between the audio ROM/lookup block and the chip audio pin.

Parameters:
CLOCK_RATE, 3_125_000, clk frequency in Hz
SAMPLE_RATE, 16_000, output sample rate in Hz; DIVIDER = CLOCK_RATE/SAMPLE_RATE (integer), must be >= MEM_LATENCY+3
ADDR_W, 14, sample memory address width
SAMPLE_W, 16, signed two's-complement sample width
PWM_BITS, 4, PWM resolution (1..SAMPLE_W)
MEM_LATENCY, 1, clk cycles from mem_rd_en sampled by memory to mem_data valid (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  global enable; low freezes all state, forces audio_out=0
start  in  1  level; sampled in IDLE, begins playback
stop  in  1  level; aborts playback
loop_mode  in  1  1=loop window, 0=one-shot; sampled at start
start_addr  in  ADDR_W  first sample address; latched at start
end_addr  in  ADDR_W  last sample address (inclusive); latched at start
vol_shift  in  2  attenuation, arithmetic right shift 0..3; sampled live at each capture
mem_addr  out  ADDR_W  read address (= current_addr)
mem_rd_en  out  1  one-cycle read strobe
mem_data  in  SAMPLE_W  read data
current_addr  out  ADDR_W  address of sample being played
busy  out  1  high in PLAY
done  out  1  one-cycle pulse at one-shot completion
audio_out  out  1  registered PWM output
level  out  PWM_BITS  PWM threshold currently in use (debug)

Behaviour:
- Reset: state IDLE; current_addr, latched window, divider, pwm counter, sample reg, level, pending threshold = 0; mem_rd_en, busy, done, audio_out = 0.
- enable=0: no register changes except audio_out<=0; pwm counter holds; in-flight read result still captured (memory is not frozen).
- States IDLE, PLAY. IDLE->PLAY on start=1 (and enable=1). PLAY->IDLE on stop=1 (priority over everything, no done) or one-shot end.
- Start edge T0: latch window/loop_mode, current_addr<=start_addr, mem_rd_en<=1, divider<=0, busy<=1. start while busy ignored.
- Capture: mem_data registered at edge T0+1+MEM_LATENCY relative to rd_en issue edge T0. Scaled = mem_data >>> vol_shift. Pending threshold = top PWM_BITS of scaled with MSB inverted (offset binary; 0x8000 -> 0, 0x0000 -> midscale, 0x7FFF -> max). No overflow possible.
- Sample tick: divider counts 0..DIVIDER-1 in PLAY; at DIVIDER-1 wrap to 0 and advance:
  - current_addr != end_addr: current_addr+1, wrapping 2^ADDR_W-1 -> 0 (end_addr < start_addr legal, window wraps). Issue mem_rd_en.
  - == end_addr, loop: current_addr<=latched start_addr, issue read.
  - == end_addr, one-shot: done<=1 for one cycle, busy<=0, IDLE, no read.
- PWM: PWM_BITS counter free-runs in PLAY; level<=pending threshold only when counter == all-ones (double-buffered, no mid-period glitch). audio_out<=(counter < level). Level 0 => constant 0.
- IDLE: pwm counter=0, audio_out=0, level retains last value.
- stop mid-read: late read data may still be captured but never reaches audio_out while IDLE; a new start reissues a read.
- mem_rd_en never high two consecutive cycles.

Decomposition:
- Package audio_pkg: state enum (IDLE, PLAY), function to_offset_level(sample, shift) returning PWM_BITS value, DIVIDER derivation helper.
- Sub-module pwm_dac: counter, double-buffered threshold, comparator, output register; params PWM_BITS.

Test Plan:
- Defaults, ROM model latency 1, start_addr=0, end_addr=3, one-shot -> rd_en at addrs 0,1,2,3 each 195 cycles apart; done pulses once 4*195 cycles after start; busy falls same edge.
- Loop, start=10, end=12 -> address sequence 10,11,12,10,11,... for 3 full loops, no done pulse.
- start_addr=16382, end_addr=1 -> addresses 16382,16383,0,1 then done.
- mem_data 0x7FFF, vol_shift=0 -> level=15, audio_out high 15 of 16 cycles; 0x8000 -> level 0, audio_out constant 0; 0x0000 with vol_shift=3 -> level 8.
- stop asserted mid-sample and simultaneous with start -> IDLE next edge, audio_out 0, no done; re-start replays from start_addr.
- enable low 50 cycles mid-play -> current_addr and divider frozen, audio_out 0; resumes with remaining divider count intact.
